// File: rtl/alarm_bank.sv
// Multi-channel HH:MM BCD alarm bank with snooze, ring timeout and buzzer.
// Define ALARM_SNOOZE_LIMIT_EN to cap snoozes per ring event at SNOOZE_MAX.
module alarm_bank #(
    parameter int N_ALARM    = 4,
    parameter int SEL_W      = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_TICKS = 6000,
    parameter int BEEP_DIV   = 50,
    parameter int SNOOZE_MAX = 3
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               ld,
    input  logic [SEL_W-1:0]   ld_sel,
    input  logic [15:0]        ld_time,
    input  logic [N_ALARM-1:0] en_mask,
    input  logic [15:0]        time_in,
    input  logic               stop,
    input  logic               snooze,
    output logic               buzz,
    output logic [N_ALARM-1:0] ringing,
    output logic               snoozing,
    output logic               ld_err
);
    localparam int RC_W = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;
    localparam int BD_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [N_ALARM-1:0] pend_q, pend_d;
    logic [N_ALARM-1:0] match_q, match_d, mprev_q;
    logic [RC_W-1:0]    ring_cnt_q, ring_cnt_d;
    logic [BD_W-1:0]    beep_q, beep_d;
    logic               buzz_q, buzz_d;
    logic [15:0]        snz_q, snz_d;
    logic               ld_err_q;
    logic [15:0]        alarm_q [N_ALARM];
    logic               ld_ok, stop_eff, snz_lim;
    logic [N_ALARM-1:0] trig, cur_oh, new_trig;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int SC_W = $clog2(SNOOZE_MAX + 1);
    logic [SC_W-1:0] snzc_q, snzc_d;
    assign snz_lim = (snzc_q == SC_W'(SNOOZE_MAX));
`else
    assign snz_lim = 1'b0;
`endif

    function automatic logic [15:0] add_snooze(input logic [15:0] t);
        int m, h;
        m = int'(t[7:4]) * 10 + int'(t[3:0]) + SNOOZE_MIN;
        h = int'(t[15:12]) * 10 + int'(t[11:8]);
        if (m >= 60) begin
            m = m - 60;
            h = h + 1;
        end
        if (h >= 24) h = h - 24;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [SEL_W-1:0] lowest(input logic [N_ALARM-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_ALARM - 1; i >= 0; i--)
            if (v[i]) r = SEL_W'(i);
        return r;
    endfunction

    assign ld_ok = ld && (32'(ld_sel) < N_ALARM)
                && (ld_time[15:12] <= 4'd2) && (ld_time[11:8] <= 4'd9)
                && !((ld_time[15:12] == 4'd2) && (ld_time[11:8] > 4'd3))
                && (ld_time[7:4] <= 4'd5) && (ld_time[3:0] <= 4'd9);

    always_comb begin
        match_d = '0;
        for (int i = 0; i < N_ALARM; i++)
            match_d[i] = en_mask[i] && (alarm_q[i] == time_in);
    end

    assign trig     = match_q & ~mprev_q;
    assign new_trig = trig & en_mask;
    assign cur_oh   = N_ALARM'(1) << cur_q;
    // Reloading or disabling the active channel ends its event like stop.
    assign stop_eff = stop || (ld_ok && (ld_sel == cur_q))
                   || ((en_mask & cur_oh) == '0);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pend_d     = (pend_q | trig) & en_mask;
        ring_cnt_d = ring_cnt_q;
        beep_d     = beep_q;
        buzz_d     = buzz_q;
        snz_d      = snz_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snzc_d     = snzc_q;
`endif
        unique case (state_q)
            IDLE: begin
                buzz_d = 1'b0;
                if (pend_d != '0) begin
                    state_d    = RING;
                    cur_d      = lowest(pend_d);
                    ring_cnt_d = '0;
                    beep_d     = '0;
                    buzz_d     = 1'b1;
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snzc_d     = '0;
`endif
                end
            end
            RING: begin
                ring_cnt_d = ring_cnt_q + 1'b1;
                if (beep_q == BD_W'(BEEP_DIV - 1)) begin
                    beep_d = '0;
                    buzz_d = ~buzz_q;
                end else begin
                    beep_d = beep_q + 1'b1;
                end
                if (stop_eff || (ring_cnt_q == RC_W'(RING_TICKS - 1))
                    || (snooze && snz_lim)) begin
                    pend_d = pend_d & ~cur_oh;
                    buzz_d = 1'b0;
                    if (pend_d != '0) begin
                        // Silent cycle first, then the next channel starts high.
                        cur_d      = lowest(pend_d);
                        ring_cnt_d = '0;
                        beep_d     = BD_W'(BEEP_DIV - 1);
`ifdef ALARM_SNOOZE_LIMIT_EN
                        snzc_d     = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else if (snooze) begin
                    pend_d  = pend_d & ~cur_oh;
                    snz_d   = add_snooze(time_in);
                    buzz_d  = 1'b0;
                    state_d = SNOOZE;
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snzc_d  = snzc_q + 1'b1;
`endif
                end
            end
            SNOOZE: begin
                buzz_d = 1'b0;
                if (stop_eff) begin
                    state_d = IDLE;
                end else if (new_trig != '0) begin
                    state_d    = RING;
                    cur_d      = lowest(new_trig);
                    ring_cnt_d = '0;
                    beep_d     = '0;
                    buzz_d     = 1'b1;
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snzc_d     = '0;
`endif
                end else if (time_in == snz_q) begin
                    state_d    = RING;
                    ring_cnt_d = '0;
                    beep_d     = '0;
                    buzz_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            pend_q     <= '0;
            match_q    <= '0;
            mprev_q    <= '0;
            ring_cnt_q <= '0;
            beep_q     <= '0;
            buzz_q     <= 1'b0;
            snz_q      <= '0;
            ld_err_q   <= 1'b0;
            for (int i = 0; i < N_ALARM; i++) alarm_q[i] <= '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snzc_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            match_q    <= match_d;
            mprev_q    <= match_q;
            ring_cnt_q <= ring_cnt_d;
            beep_q     <= beep_d;
            buzz_q     <= buzz_d;
            snz_q      <= snz_d;
            ld_err_q   <= ld && !ld_ok;
            for (int i = 0; i < N_ALARM; i++)
                if (ld_ok && (ld_sel == SEL_W'(i))) alarm_q[i] <= ld_time;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snzc_q     <= snzc_d;
`endif
        end
    end

    assign buzz     = buzz_q;
    assign ringing  = (state_q == RING) ? cur_oh : '0;
    assign snoozing = (state_q == SNOOZE);
    assign ld_err   = ld_err_q;
endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
Parametrised multi-channel alarm unit for the digital clock; successor to the single-alarm block.
- Holds N_ALARM independent HH:MM BCD alarm times.
- Compares each enabled channel against the running time from the counter, arbitrates simultaneous triggers, and drives the buzzer.
- Supports stop, snooze and ring timeout.
- Runs on the 100 Hz control clock; loaded from the existing load mux (buttons or UART).

Parameters:
N_ALARM, 4, number of alarm channels (1..8)
SEL_W, 2, width of channel select; must satisfy 2**SEL_W >= N_ALARM
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_TICKS, 6000, clk ticks a ring lasts before auto-stop (60 s at 100 Hz)
BEEP_DIV, 50, clk ticks per buzzer half-period
SNOOZE_MAX, 3, snoozes allowed per ring event (used only with ALARM_SNOOZE_LIMIT_EN)

Ports:
clk  in  1  control clock, rising edge
reset_  in  1  asynchronous, active-low reset
ld  in  1  one-cycle load strobe
ld_sel  in  SEL_W  channel to load
ld_time  in  16  {H1,H0,M1,M0} BCD, 4 bits each
en_mask  in  N_ALARM  per-channel enable, level
time_in  in  16  current time {H1,H0,M1,M0} BCD from counter
stop  in  1  one-cycle pulse, debounced
snooze  in  1  one-cycle pulse, debounced
buzz  out  1  buzzer drive
ringing  out  N_ALARM  one-hot, channel currently ringing
snoozing  out  1  snooze pending
ld_err  out  1  one-cycle pulse, load rejected

Behaviour:
Reset:
- All alarm registers 00:00; pending mask 0; FSM IDLE.
- buzz=0, ringing=0, snoozing=0, ld_err=0; counters 0.

Load:
- Load is accepted when ld=1, ld_sel<N_ALARM, H1<=2, H0<=9, (H1==2 implies H0<=3), M1<=5 and M0<=9; the channel register updates at that edge.
- Any other load leaves registers unchanged and pulses ld_err the next cycle.
- Loading the channel that is currently ringing or snoozing ends that event, handled exactly as a stop.

Trigger:
- match[i] = en_mask[i] && (alarm[i]==time_in), registered each cycle.
- A trigger is the rising edge of registered match, so one trigger per minute occurrence.
- ringing/buzz assert on the 2nd rising clk edge after time_in first equals the alarm.
- Triggers set pending[i]. Deasserting en_mask[i] clears pending[i]; if channel i is the active channel, this acts as stop.

FSM states:
IDLE
- Go to RING when pending != 0.
- Selects the lowest-index pending channel as cur.
RING
- ringing[cur]=1.
- buzz starts at 1 and toggles every BEEP_DIV ticks.
- ring_cnt counts up from 0.
- On stop, or ring_cnt==RING_TICKS-1: clear pending[cur]. Go to RING with the next lowest pending channel if one exists, else IDLE. buzz=0 for at least 1 cycle between events.
- On snooze: clear pending[cur]; snz_time = time_in + SNOOZE_MIN minutes, BCD with wrap 59->00 incrementing hour and 23:59->00:xx; go to SNOOZE.
SNOOZE
- snoozing=1, buzz=0.
- When time_in==snz_time, re-enter RING with the same cur; ring_cnt resets.
- A new trigger on any channel cancels the snooze (snoozing=0) and goes to RING for that channel.
- stop cancels the snooze and goes to IDLE.
- snooze is ignored in this state.

Simultaneous events and boundaries:
- stop and snooze in the same cycle: stop wins.
- snooze and stop are ignored in IDLE.
- A trigger arriving during RING only sets its pending bit.
- Re-triggering the channel that is ringing has no effect.
- Reset mid-ring returns to IDLE with buzz=0 immediately (asynchronous).

Optional Feature:
ALARM_SNOOZE_LIMIT_EN
- Defined:
  - A per-event snooze counter (reset to 0 when a new channel enters RING from IDLE or pending) counts accepted snoozes.
  - A snooze when count==SNOOZE_MAX is treated as stop.
- Undefined:
  - Snooze is unlimited.
  - The counter and SNOOZE_MAX logic are absent.

Test Plan:
1. Load ch1=07:30, en_mask=4'b0010, time_in steps 07:29->07:30 -> ringing=4'b0010 on 2nd edge, buzz toggles every 50 cycles; stop -> buzz=0, ringing=0 next cycle.
2. ch0=ch2=06:00, both enabled, time_in=06:00 -> ch0 rings first; stop -> ch2 rings; stop -> IDLE.
3. ch3 rings at 23:58, snooze -> snoozing=1, snz_time=00:03; time_in=00:03 -> ringing=4'b1000 again.
4. Load ld_time=24:00, and separately ld_sel=5 with N_ALARM=4 -> ld_err pulse each time, registers unchanged.
5. Ring left untouched -> auto-stop after exactly 6000 cycles; with ALARM_SNOOZE_LIMIT_EN, 4th snooze -> IDLE.
6. stop and snooze asserted in the same cycle during RING -> IDLE, snoozing=0; reset_ low mid-RING -> buzz=0 asynchronously.
